a1339_spi_responder: RTL and testbench
======================================

A1339_SPI_RESPONDER -- requirements
Module: a1339_spi_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on sck_i, ss_n_i and mosi_i; legal range 2..4.
REQ-002 Parameter FRAME_BITS, default 20, frame length (16 data + 4 CRC); fixed at 20, any other value is unsupported.
REQ-003 clock  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 sck_i  in  1  SPI clock from master; mode 3 (CPOL=1, CPHA=1); asynchronous to clock.
REQ-006 ss_n_i  in  1  active-low slave select; asynchronous.
REQ-007 mosi_i  in  1  master-to-slave data, MSB first; asynchronous.
REQ-008 miso_o  out  1  slave-to-master data, MSB first.
REQ-009 angle_i  in  16  live angle word served on read-angle responses.
REQ-010 crc_inject_i  in  1  when high at frame start, the response CRC of that frame is inverted.
REQ-011 cmd_o  out  16  last command word with a valid CRC.
REQ-012 cmd_valid_o  out  1  one-cycle pulse when cmd_o updates.
REQ-013 crc_error_o  out  1  one-cycle pulse on a 20-bit frame with a bad CRC.
REQ-014 frame_error_o  out  1  one-cycle pulse on a frame whose bit count is not 20.
REQ-015 frame_count_o  out  32  count of complete 20-bit frames, wraps modulo 2^32.
REQ-016 crc_error_count_o  out  16  count of CRC failures, saturates at 0xFFFF.

Function
REQ-017 sck_i, ss_n_i and mosi_i SHALL each pass through SYNC_STAGES flops; all edge detection uses synchronized values only.
REQ-018 Supported SPI timing: SCK high and low phases each >= SYNC_STAGES+2 clock periods; ss_n setup/hold to SCK >= 1 SCK half-period.
REQ-019 FSM states: IDLE, SHIFT, CHECK.
REQ-020 IDLE -> SHIFT on synchronized ss_n falling edge.
  - Latch the response word and crc_inject_i.
  - Clear bit counter and receive register.
  - Drive miso_o = response bit 19.
REQ-021 In SHIFT, each synchronized SCK rising edge shifts mosi into the receive register LSB and increments the bit counter (5 bits, saturating at 31).
REQ-022 In SHIFT, each synchronized SCK falling edge after the first rising edge advances miso_o to the next lower response bit; after bit 0, miso_o = 1.
REQ-023 SHIFT -> CHECK on synchronized ss_n rising edge; CHECK -> IDLE after exactly one cycle.
REQ-024 CHECK, bit count != 20:
  - Pulse frame_error_o.
  - cmd_o, the response selector and both counters are unchanged.
REQ-025 CHECK, bit count == 20:
  - Increment frame_count_o.
  - Compute the CRC over received bits [19:4] and compare with bits [3:0].
REQ-026 CRC match: cmd_o <= bits [19:4] and cmd_valid_o pulses in the same cycle.
REQ-027 CRC mismatch: crc_error_o pulses, crc_error_count_o increments (saturating), cmd_o is held.
REQ-028 CRC algorithm, 4-bit state c3..c0, init 4'hF; per data bit, MSB first:
  - inv = bit ^ c3
  - c3 <= c2; c2 <= c1; c1 <= c0 ^ inv; c0 <= inv
  - result {c3,c2,c1,c0}
  - Check values: CRC(0x2000) = 4'h9; CRC(0x0000) = 4'hD.
REQ-029 The CRC may be computed serially during SHIFT or combinationally in CHECK; the result SHALL be available in CHECK.
REQ-030 Response is pipelined, selected by the last CRC-valid command (frame N answers frame N-1):
  - cmd_o[15:8] == 8'h20: data = angle_i sampled at frame start.
  - Otherwise: data = {crc_error_count_o[7:0], frame_count_o[7:0]}.
  - Response = {data, CRC(data)}, CRC field XOR 4'hF if crc_inject_i was latched.
REQ-031 ss_n deasserted: miso_o = 1; SCK edges are ignored.
REQ-032 ss_n rising edge in the same cycle as an SCK edge: the ss_n edge wins and the SCK edge is discarded.

Reset
REQ-033 While reset is high, at each rising clock edge:
  - FSM = IDLE; miso_o = 1.
  - cmd_o = 0x0000; cmd_valid_o = crc_error_o = frame_error_o = 0.
  - frame_count_o = 0; crc_error_count_o = 0.
  - Synchronizers filled with idle levels: sck = 1, ss_n = 1, mosi = 1.
  - Response selector = read-angle.
REQ-034 Reset asserted mid-frame aborts the frame with no pulses and no counter update; after release the block waits for the next ss_n falling edge.

Verification
REQ-035 After reset, angle_i = 0x0000, master sends 0x20009 -> miso carries 0x0000D; cmd_o = 0x2000, cmd_valid_o pulses once, frame_count_o = 1.
REQ-036 Send 0x20008 (bad CRC) -> crc_error_o pulses, crc_error_count_o = 1, cmd_o unchanged, frame_count_o increments.
REQ-037 Send 0x00000 (CRC 0x0 vs expected 0xD) -> CRC error; then send 0x0000D -> cmd_o = 0x0000; the next frame's response data = {crc_error_count_o[7:0], frame_count_o[7:0]} with matching CRC.
REQ-038 Deassert ss_n after 12 SCK cycles -> frame_error_o pulses; frame_count_o, cmd_o and crc_error_count_o unchanged.
REQ-039 crc_inject_i = 1 at frame start, angle_i = 0x0000 -> response = 0x00002 (CRC inverted); the next frame without injection returns the correct CRC.
REQ-040 Reset asserted after 10 SCK edges -> no pulses, all outputs at reset values; the following complete 0x20009 frame is processed normally.

Source files
------------

// File: rtl/a1339_spi_responder.sv
// SPI mode-3 responder for an angle-sensor style link: 20-bit frames (16 data + 4 CRC),
// responses answer the previous CRC-valid command, everything runs in the system clock domain.
module a1339_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = 20
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sck_i,
    input  logic        ss_n_i,
    input  logic        mosi_i,
    output logic        miso_o,
    input  logic [15:0] angle_i,
    input  logic        crc_inject_i,
    output logic [15:0] cmd_o,
    output logic        cmd_valid_o,
    output logic        crc_error_o,
    output logic        frame_error_o,
    output logic [31:0] frame_count_o,
    output logic [15:0] crc_error_count_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    // 4-bit CRC, init 0xF, data MSB first
    function automatic logic [3:0] crc4(input logic [15:0] data);
        logic [3:0] c;
        logic       inv;
        c = 4'hF;
        for (int i = 15; i >= 0; i--) begin
            inv = data[i] ^ c[3];
            c   = {c[2], c[1], c[0] ^ inv, inv};
        end
        return c;
    endfunction

    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] ss_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sck_d_r;
    logic                   ss_d_r;

    logic                   sck_s;
    logic                   ss_s;
    logic                   mosi_s;
    logic                   sck_rise_s;
    logic                   sck_fall_s;
    logic                   ss_rise_s;
    logic                   ss_fall_s;

    state_t                 state_r;
    logic [19:0]            rx_r;
    logic [19:0]            resp_r;
    logic [4:0]             bit_cnt_r;
    logic                   seen_rise_r;
    logic                   sel_angle_r;

    logic [15:0]            resp_data_s;
    logic [3:0]             resp_crc_s;
    logic [3:0]             rx_crc_s;

    // Synchronizer chains; reset fills them with the bus idle levels
    always_ff @(posedge clock) begin
        if (reset) begin
            sck_sync_r  <= {SYNC_STAGES{1'b1}};
            ss_sync_r   <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b1}};
            sck_d_r     <= 1'b1;
            ss_d_r      <= 1'b1;
        end else begin
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], sck_i};
            ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], ss_n_i};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi_i};
            sck_d_r     <= sck_sync_r[SYNC_STAGES-1];
            ss_d_r      <= ss_sync_r[SYNC_STAGES-1];
        end
    end

    // Edge detection on synchronized levels only
    always_comb begin
        sck_s      = sck_sync_r[SYNC_STAGES-1];
        ss_s       = ss_sync_r[SYNC_STAGES-1];
        mosi_s     = mosi_sync_r[SYNC_STAGES-1];
        sck_rise_s = sck_s & ~sck_d_r;
        sck_fall_s = ~sck_s & sck_d_r;
        ss_rise_s  = ss_s & ~ss_d_r;
        ss_fall_s  = ~ss_s & ss_d_r;
    end

    // Response word candidate and received-frame CRC
    always_comb begin
        resp_data_s = 16'h0000;
        if (sel_angle_r) begin
            resp_data_s = angle_i;
        end else begin
            resp_data_s = {crc_error_count_o[7:0], frame_count_o[7:0]};
        end
        if (crc_inject_i) begin
            resp_crc_s = crc4(resp_data_s) ^ 4'hF;
        end else begin
            resp_crc_s = crc4(resp_data_s);
        end
        rx_crc_s = crc4(rx_r[19:4]);
    end

    // Frame FSM with registered outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r           <= IDLE;
            miso_o            <= 1'b1;
            cmd_o             <= 16'h0000;
            cmd_valid_o       <= 1'b0;
            crc_error_o       <= 1'b0;
            frame_error_o     <= 1'b0;
            frame_count_o     <= 32'd0;
            crc_error_count_o <= 16'd0;
            rx_r              <= 20'd0;
            resp_r            <= 20'hFFFFF;
            bit_cnt_r         <= 5'd0;
            seen_rise_r       <= 1'b0;
            sel_angle_r       <= 1'b1;
        end else begin
            cmd_valid_o   <= 1'b0;
            crc_error_o   <= 1'b0;
            frame_error_o <= 1'b0;
            case (state_r)
                IDLE: begin
                    miso_o <= 1'b1;
                    if (ss_fall_s) begin
                        state_r     <= SHIFT;
                        resp_r      <= {resp_data_s, resp_crc_s};
                        miso_o      <= resp_data_s[15];
                        rx_r        <= 20'd0;
                        bit_cnt_r   <= 5'd0;
                        seen_rise_r <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    // ss_n release takes priority over any coincident SCK edge
                    if (ss_rise_s) begin
                        state_r <= CHECK;
                        miso_o  <= 1'b1;
                    end else if (sck_rise_s) begin
                        rx_r        <= {rx_r[18:0], mosi_s};
                        seen_rise_r <= 1'b1;
                        if (bit_cnt_r != 5'd31) begin
                            bit_cnt_r <= bit_cnt_r + 5'd1;
                        end else begin
                            bit_cnt_r <= bit_cnt_r;
                        end
                    end else if (sck_fall_s && seen_rise_r) begin
                        resp_r <= {resp_r[18:0], 1'b1};
                        miso_o <= resp_r[18];
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                CHECK: begin
                    state_r <= IDLE;
                    miso_o  <= 1'b1;
                    if (bit_cnt_r != 5'(FRAME_BITS)) begin
                        frame_error_o <= 1'b1;
                    end else begin
                        frame_count_o <= frame_count_o + 32'd1;
                        if (rx_crc_s == rx_r[3:0]) begin
                            cmd_o       <= rx_r[19:4];
                            cmd_valid_o <= 1'b1;
                            sel_angle_r <= (rx_r[19:12] == 8'h20);
                        end else begin
                            crc_error_o <= 1'b1;
                            if (crc_error_count_o != 16'hFFFF) begin
                                crc_error_count_o <= crc_error_count_o + 16'd1;
                            end else begin
                                crc_error_count_o <= crc_error_count_o;
                            end
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    miso_o  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a1339_spi_responder.sv
// Directed bench: a table of complete SPI frames with hand-computed responses and
// status, plus hand-written reset and mid-frame-abort sequences.
module tb_a1339_spi_responder;

    localparam int HALF = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sck_i = 1'b1;
    logic        ss_n_i = 1'b1;
    logic        mosi_i = 1'b1;
    logic        miso_o;
    logic [15:0] angle_i = 16'h0000;
    logic        crc_inject_i = 1'b0;
    logic [15:0] cmd_o;
    logic        cmd_valid_o;
    logic        crc_error_o;
    logic        frame_error_o;
    logic [31:0] frame_count_o;
    logic [15:0] crc_error_count_o;

    int errors = 0;
    int checks = 0;
    int n_valid = 0;
    int n_crcerr = 0;
    int n_frerr = 0;

    a1339_spi_responder dut (
        .clock(clock), .reset(reset), .sck_i(sck_i), .ss_n_i(ss_n_i), .mosi_i(mosi_i),
        .miso_o(miso_o), .angle_i(angle_i), .crc_inject_i(crc_inject_i), .cmd_o(cmd_o),
        .cmd_valid_o(cmd_valid_o), .crc_error_o(crc_error_o), .frame_error_o(frame_error_o),
        .frame_count_o(frame_count_o), .crc_error_count_o(crc_error_count_o)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (cmd_valid_o)   n_valid++;
        if (crc_error_o)   n_crcerr++;
        if (frame_error_o) n_frerr++;
    end

    typedef struct {
        logic [19:0] tx;
        int          nbits;
        logic [15:0] angle;
        logic        inject;
        logic [19:0] exp_rx;
        logic [15:0] exp_cmd;
        int          exp_valid;
        int          exp_crcerr;
        int          exp_frerr;
        logic [31:0] exp_fc;
        logic [15:0] exp_cec;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Master side of one frame: nbits SCK cycles, miso captured just before each rising edge.
    // angle_i and crc_inject_i are disturbed after the frame starts to prove they were latched.
    task automatic spi_frame(input logic [19:0] tx, input int nbits, input logic [15:0] angle,
                             input logic inject, output logic [19:0] rx);
        rx = 20'd0;
        angle_i = angle;
        crc_inject_i = inject;
        clks(2);
        ss_n_i = 1'b0;
        clks(HALF);
        angle_i = ~angle;
        crc_inject_i = ~inject;
        for (int i = 0; i < nbits; i++) begin
            sck_i = 1'b0;
            mosi_i = tx[19 - i];
            clks(HALF);
            rx = {rx[18:0], miso_o};
            sck_i = 1'b1;
            clks(HALF);
        end
        ss_n_i = 1'b1;
        mosi_i = 1'b1;
        clks(10);
        crc_inject_i = 1'b0;
    endtask

    initial begin
        logic [19:0] rx;

        vecs[0] = '{20'h20009, 20, 16'h0000, 1'b0, 20'h0000D, 16'h2000, 1, 0, 0, 32'd1, 16'd0};
        vecs[1] = '{20'h20008, 20, 16'h2000, 1'b0, 20'h20009, 16'h2000, 0, 1, 0, 32'd2, 16'd1};
        vecs[2] = '{20'h00000, 20, 16'h0000, 1'b0, 20'h0000D, 16'h2000, 0, 1, 0, 32'd3, 16'd2};
        vecs[3] = '{20'h0000D, 20, 16'h2000, 1'b0, 20'h20009, 16'h0000, 1, 0, 0, 32'd4, 16'd2};
        vecs[4] = '{20'h20009, 20, 16'h1111, 1'b0, 20'h0204C, 16'h2000, 1, 0, 0, 32'd5, 16'd2};
        vecs[5] = '{20'h20009, 12, 16'h0000, 1'b0, 20'h00000, 16'h2000, 0, 0, 1, 32'd5, 16'd2};
        vecs[6] = '{20'h20009, 20, 16'h0000, 1'b1, 20'h00002, 16'h2000, 1, 0, 0, 32'd6, 16'd2};
        vecs[7] = '{20'h20009, 20, 16'h0000, 1'b0, 20'h0000D, 16'h2000, 1, 0, 0, 32'd7, 16'd2};

        clks(5);
        check("reset_miso", {31'd0, miso_o}, 32'd1);
        check("reset_cmd", {16'd0, cmd_o}, 32'd0);
        check("reset_fc", frame_count_o, 32'd0);
        check("reset_cec", {16'd0, crc_error_count_o}, 32'd0);
        check("reset_pulses", {29'd0, cmd_valid_o, crc_error_o, frame_error_o}, 32'd0);
        reset = 1'b0;
        clks(5);

        for (int v = 0; v < 8; v++) begin
            n_valid = 0; n_crcerr = 0; n_frerr = 0;
            spi_frame(vecs[v].tx, vecs[v].nbits, vecs[v].angle, vecs[v].inject, rx);
            check($sformatf("v%0d_miso", v), {12'd0, rx}, {12'd0, vecs[v].exp_rx});
            check($sformatf("v%0d_cmd", v), {16'd0, cmd_o}, {16'd0, vecs[v].exp_cmd});
            check($sformatf("v%0d_valid", v), n_valid, vecs[v].exp_valid);
            check($sformatf("v%0d_crcerr", v), n_crcerr, vecs[v].exp_crcerr);
            check($sformatf("v%0d_frerr", v), n_frerr, vecs[v].exp_frerr);
            check($sformatf("v%0d_fc", v), frame_count_o, vecs[v].exp_fc);
            check($sformatf("v%0d_cec", v), {16'd0, crc_error_count_o}, {16'd0, vecs[v].exp_cec});
        end

        // Abort a frame with reset after 10 SCK edges
        n_valid = 0; n_crcerr = 0; n_frerr = 0;
        ss_n_i = 1'b0;
        clks(HALF);
        for (int i = 0; i < 5; i++) begin
            sck_i = 1'b0;
            mosi_i = 1'b0;
            clks(HALF);
            sck_i = 1'b1;
            clks(HALF);
        end
        reset = 1'b1;
        clks(3);
        ss_n_i = 1'b1;
        mosi_i = 1'b1;
        clks(4);
        reset = 1'b0;
        clks(10);
        check("abort_pulses", n_valid + n_crcerr + n_frerr, 32'd0);
        check("abort_miso", {31'd0, miso_o}, 32'd1);
        check("abort_cmd", {16'd0, cmd_o}, 32'd0);
        check("abort_fc", frame_count_o, 32'd0);
        check("abort_cec", {16'd0, crc_error_count_o}, 32'd0);

        n_valid = 0; n_crcerr = 0; n_frerr = 0;
        spi_frame(20'h20009, 20, 16'h0000, 1'b0, rx);
        check("post_miso", {12'd0, rx}, 32'h0000D);
        check("post_cmd", {16'd0, cmd_o}, 32'h2000);
        check("post_valid", n_valid, 32'd1);
        check("post_fc", frame_count_o, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
